main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter LAT, default 4, giving access latency in cycles (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, line request present.
REQ-005 SHALL have port req_ready, output, 1, responder accepts a request this cycle.
REQ-006 SHALL have port req_write, input, 1, 1 = line write-back, 0 = line fill.
REQ-007 SHALL have port req_addr, input, 12, line address (word address bits 14:3).
REQ-008 SHALL have ports wdata_valid (input, 1), wdata_ready (output, 1), and wdata (input, 16), the write-beat channel.
REQ-009 SHALL have ports rdata_valid (output, 1), rdata_ready (input, 1), rdata (output, 16), and rdata_last (output, 1), the read-beat channel.
REQ-010 SHALL have port wr_done, output, 1, a one-cycle pulse when a write-back line commits.

Function
REQ-011 SHALL store 4096 lines of 128 bits, each line being 8 words of 16 bits; beat k carries line bits [16k+15:16k], k = 0..7.
REQ-012 SHALL implement states IDLE, WDATA, WDONE, WAIT, and RBURST.
REQ-013 In IDLE, req_ready SHALL be 1; a handshake (req_valid & req_ready) SHALL latch req_addr and req_write.
REQ-014 After a write handshake, the block SHALL move to WDATA with beat counter 0.
REQ-015 After a read handshake, the block SHALL move to WAIT with its latency counter loaded.
REQ-016 In WDATA, wdata_ready SHALL be 1; each wdata_valid beat SHALL fill word[beat] of a line buffer and increment the beat counter.
REQ-017 On the 8th write beat, the buffered 128-bit line SHALL commit to memory at the latched address on that edge, and the block SHALL move to WDONE.
REQ-018 WDONE SHALL assert wr_done for exactly one cycle and then return to IDLE.
REQ-019 In WAIT, the first rdata_valid SHALL assert exactly LAT cycles after the request-handshake edge.
REQ-020 When WAIT expires, the addressed line SHALL be snapshotted into the line buffer and the block SHALL enter RBURST.
REQ-021 In RBURST, rdata_valid SHALL be 1 and rdata SHALL equal word[beat]; the beat counter SHALL advance only on rdata_valid & rdata_ready, and rdata and rdata_valid SHALL hold while rdata_ready is 0.
REQ-022 rdata_last SHALL be 1 exactly when rdata_valid is 1 and beat = 7; the handshake on that beat SHALL return the block to IDLE.
REQ-023 Outside IDLE, req_ready SHALL be 0 and req_valid SHALL be ignored; consecutive transactions SHALL therefore be separated by at least one IDLE cycle.
REQ-024 wdata_valid SHALL be ignored outside WDATA; rdata_ready SHALL be ignored outside RBURST.
REQ-025 Beat and latency counters SHALL be 3 and 4 bits wide; the beat counter SHALL wrap 7 -> 0 only as part of a state exit.
REQ-026 A write followed by a read of the same line SHALL return the written data (read-after-write coherent).

Reset
REQ-027 While rst = 1, the block SHALL be in IDLE; req_ready SHALL be 1; wdata_ready, rdata_valid, rdata_last, and wr_done SHALL be 0; rdata SHALL be 0; and counters SHALL be 0.
REQ-028 Reset mid-WDATA SHALL discard partial beats, leaving the memory line unmodified; reset mid-WAIT or mid-RBURST SHALL abort the burst with no further beats.
REQ-029 Memory contents SHALL be unaffected by rst, and SHALL be zero at time zero.

Structure
REQ-030 The shared package mem_pkg SHALL hold WORD_W = 16, BEATS = 8, LINE_W = 128, LINE_ADDR_W = 12, and the state enumeration, for reuse by the cache side.
REQ-031 Storage SHALL be a single sub-module mm_array: 4096x128, one read port and one write port, with synchronous write and a read usable in the WAIT-expiry cycle.

Verification
REQ-032 The bench SHALL cover: write line 0x005 with beats 0x1000..0x1007 -> wr_done pulses one cycle after beat 8; a subsequent read of 0x005 returns 0x1000..0x1007 in order, with rdata_last on 0x1007.
REQ-033 The bench SHALL cover: LAT = 4, read of line 0xFFF after reset -> first rdata_valid exactly 4 cycles after the handshake, and all 8 beats are 0x0000.
REQ-034 The bench SHALL cover: read with rdata_ready toggling 1,0,0,1,... -> rdata holds while stalled, no beat is skipped or duplicated, and exactly 8 handshakes occur.
REQ-035 The bench SHALL cover: rst asserted after 5 write beats to line 0x0A0 -> a later read of 0x0A0 returns the old contents.
REQ-036 The bench SHALL cover: req_valid held high during RBURST with a different address -> req_ready is 0 and the request is accepted only in the IDLE cycle after rdata_last.
REQ-037 The bench SHALL cover: LAT = 1 -> rdata_valid asserts on the cycle immediately after the request handshake.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared main-memory definitions: line geometry and responder state encoding.
package mem_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned BEATS       = 8;
  localparam int unsigned LINE_W      = WORD_W * BEATS;
  localparam int unsigned LINE_ADDR_W = 12;
  localparam int unsigned BEAT_W      = 3;
  localparam int unsigned LAT_W       = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StWdone,
    StWait,
    StRburst
  } mm_state_e;

  // Extract word idx of a line; beat k lives in bits [16k+15:16k].
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [BEAT_W-1:0] idx);
    return line[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/mm_array.sv
// Line storage: 4096 x 128, synchronous write port, combinational read port.
module mm_array
  import mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   we,
  input  logic [LINE_ADDR_W-1:0] waddr,
  input  logic [LINE_W-1:0]      wdata,
  input  logic [LINE_ADDR_W-1:0] raddr,
  output logic [LINE_W-1:0]      rdata
);

  // Contents start at zero and are never touched by reset.
  logic [LINE_W-1:0] mem_q [2**LINE_ADDR_W] = '{default: '0};

  // Commit a full line on the write edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read is combinational so the line is available in the cycle the wait expires.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: accepts line fills and write-backs, streams 8 beats per line.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [15:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [15:0] rdata,
  output logic        rdata_last,
  output logic        wr_done
);

  // Wait counter counts down to zero; LAT cycles of WAIT put the first beat LAT edges out.
  localparam logic [LAT_W-1:0] LatInit = LAT_W'(LAT - 1);

  mm_state_e              state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [LINE_ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0]      line_q;
  logic [LINE_W-1:0]      rd_line;
  logic [LINE_W-1:0]      wr_line;
  logic                   wr_en;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state, counter updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    wr_done     = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          beat_d = '0;
          if (req_write) begin
            state_d = StWdata;
          end else begin
            state_d = StWait;
            lat_d   = LatInit;
          end
        end
      end
      StWdata: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == 3'd7) begin
            wr_en   = 1'b1;
            state_d = StWdone;
          end
        end
      end
      StWdone: begin
        wr_done = 1'b1;
        state_d = StIdle;
      end
      StWait: begin
        if (lat_q == '0) begin
          state_d = StRburst;
          beat_d  = '0;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StRburst: begin
        rdata_valid = 1'b1;
        rdata_last  = (beat_q == 3'd7);
        if (rdata_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == 3'd7) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Latched address and line buffer (write assembly / read snapshot).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      line_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q <= req_addr;
          end
        end
        StWdata: begin
          if (wdata_valid) begin
            line_q[beat_q*WORD_W +: WORD_W] <= wdata;
          end
        end
        StWait: begin
          if (lat_q == '0) begin
            line_q <= rd_line;
          end
        end
        default: ;
      endcase
    end
  end

  // The final beat bypasses the buffer so the whole line commits on the 8th edge.
  always_comb begin
    wr_line = line_q;
    wr_line[beat_q*WORD_W +: WORD_W] = wdata;
  end

  assign rdata = rdata_valid ? line_word(line_q, beat_q) : '0;

  mm_array u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (addr_q),
    .wdata (wr_line),
    .raddr (addr_q),
    .rdata (rd_line)
  );

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder (LAT=4 instance plus a LAT=1 instance).
module tb_main_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic        wdata_valid, wdata_ready;
  logic [15:0] wdata;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [15:0] rdata;
  logic        wr_done;

  logic        p1_req_valid, p1_req_ready;
  logic [11:0] p1_req_addr;
  logic        p1_wdata_ready;
  logic        p1_rdata_valid, p1_rdata_ready, p1_rdata_last;
  logic [15:0] p1_rdata;
  logic        p1_wr_done;

  int n_tests = 0;
  int n_fail  = 0;

  main_mem_responder #(.LAT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .rdata_last  (rdata_last),
    .wr_done     (wr_done)
  );

  main_mem_responder #(.LAT(1)) dut_lat1 (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (p1_req_valid),
    .req_ready   (p1_req_ready),
    .req_write   (1'b0),
    .req_addr    (p1_req_addr),
    .wdata_valid (1'b0),
    .wdata_ready (p1_wdata_ready),
    .wdata       (16'h0000),
    .rdata_valid (p1_rdata_valid),
    .rdata_ready (p1_rdata_ready),
    .rdata       (p1_rdata),
    .rdata_last  (p1_rdata_last),
    .wr_done     (p1_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake edge.
  task automatic issue_req(input logic wr, input logic [11:0] a);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic write_line(input string tag, input logic [11:0] a, input logic [15:0] base,
                            input int nbeats);
    issue_req(1'b1, a);
    check({tag, "_wready"}, 32'(wdata_ready), 32'd1);
    for (int k = 0; k < nbeats; k++) begin
      wdata_valid = 1'b1;
      wdata       = base + 16'(k);
      @(negedge clk);
      if (k < 7) check({tag, "_no_done"}, 32'(wr_done), 32'd0);
    end
    wdata_valid = 1'b0;
    if (nbeats == 8) begin
      check({tag, "_done"}, 32'(wr_done), 32'd1);
      @(negedge clk);
      check({tag, "_done_once"}, 32'(wr_done), 32'd0);
      check({tag, "_idle"}, 32'(req_ready), 32'd1);
    end
  endtask

  // mode 0: always ready; 1: ready 1,0,0 repeating; 2: always ready, new request held high.
  task automatic collect(input string tag, input int exp_lat, input logic [15:0] base,
                         input logic [15:0] inc, input int mode, input logic [11:0] hold_addr);
    int   cyc;
    int   idx;
    int   step;
    logic rdy;
    cyc = 0;
    while (!rdata_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    idx  = 0;
    step = 0;
    while (idx < 8 && step < 64) begin
      if (!rdata_valid) begin
        check({tag, "_valid"}, 32'd0, 32'd1);
        break;
      end
      check({tag, "_data"}, 32'(rdata), 32'(base + inc * 16'(idx)));
      check({tag, "_last"}, 32'(rdata_last), 32'(idx == 7));
      if (mode == 2) begin
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = hold_addr;
        check({tag, "_busy"}, 32'(req_ready), 32'd0);
      end
      rdy = (mode == 1) ? (step % 3 == 0) : 1'b1;
      rdata_ready = rdy;
      if (rdy) idx++;
      step++;
      @(negedge clk);
    end
    rdata_ready = 1'b0;
    check({tag, "_beats"}, 32'(idx), 32'd8);
    check({tag, "_end"}, 32'(rdata_valid), 32'd0);
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_wready"}, 32'(wdata_ready), 32'd0);
    check({tag, "_rvalid"}, 32'(rdata_valid), 32'd0);
    check({tag, "_rlast"}, 32'(rdata_last), 32'd0);
    check({tag, "_wr_done"}, 32'(wr_done), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic seen;
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_addr       = '0;
    wdata_valid    = 1'b0;
    wdata          = '0;
    rdata_ready    = 1'b0;
    p1_req_valid   = 1'b0;
    p1_req_addr    = '0;
    p1_rdata_ready = 1'b0;

    @(negedge clk);
    reset_pulse("rst0");

    // Untouched line reads as zero, first beat 4 edges after the handshake.
    issue_req(1'b0, 12'hFFF);
    collect("rd_fff", 4, 16'h0000, 16'h0000, 0, 12'h000);

    // Write-back then read-after-write of the same line.
    write_line("wr_005", 12'h005, 16'h1000, 8);
    issue_req(1'b0, 12'h005);
    collect("rd_005", 4, 16'h1000, 16'h0001, 0, 12'h000);

    // Back-pressured read.
    issue_req(1'b0, 12'h005);
    collect("rd_stall", 4, 16'h1000, 16'h0001, 1, 12'h000);

    // Partial write aborted by reset leaves the old line intact.
    write_line("wr_0a0", 12'h0A0, 16'h2000, 8);
    write_line("wr_part", 12'h0A0, 16'h3000, 5);
    reset_pulse("rst_mid");
    issue_req(1'b0, 12'h0A0);
    collect("rd_0a0", 4, 16'h2000, 16'h0001, 0, 12'h000);

    // Request held during a burst is taken only in the following idle cycle.
    issue_req(1'b0, 12'h005);
    collect("rd_hold", 4, 16'h1000, 16'h0001, 2, 12'h0A0);
    @(negedge clk);
    req_valid = 1'b0;
    collect("rd_next", 4, 16'h2000, 16'h0001, 0, 12'h000);

    // Reset during WAIT aborts the burst.
    issue_req(1'b0, 12'h005);
    @(negedge clk);
    reset_pulse("rst_wait");
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rdata_valid) seen = 1'b1;
    end
    check("abort_wait", 32'(seen), 32'd0);

    // LAT=1 instance: valid on the edge right after the handshake.
    check("lat1_ready", 32'(p1_req_ready), 32'd1);
    p1_req_valid = 1'b1;
    p1_req_addr  = 12'h123;
    @(negedge clk);
    p1_req_valid = 1'b0;
    check("lat1_wait", 32'(p1_rdata_valid), 32'd0);
    @(negedge clk);
    check("lat1_valid", 32'(p1_rdata_valid), 32'd1);
    check("lat1_data", 32'(p1_rdata), 32'd0);
    p1_rdata_ready = 1'b1;
    repeat (8) @(negedge clk);
    p1_rdata_ready = 1'b0;
    check("lat1_end", 32'(p1_rdata_valid), 32'd0);
    check("lat1_idle", 32'(p1_req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
